msrv32_instr_queue_decode: RTL and testbench
============================================

Name: msrv32_instr_queue_decode

Overview:
- Parametrised successor to the combinational instruction field splitter.
- Buffers fetched instructions and their PCs in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Splits the head entry into RV32 fields. Flush squashes the queue and zeroes all field outputs.
- Sits between the instruction-memory interface and the decoder / register-file read stage.

Parameters:
- DEPTH, 4: number of queue entries; power of 2, at least 2.
- PC_W, 32: PC width carried alongside each instruction.
- CNT_W, $clog2(DEPTH)+1: occupancy counter width; derived, do not override.

Ports:
- ms_riscv32_mp_clk_in  input  1  core clock; all state updates on the rising edge.
- ms_riscv32_mp_rst_n_in  input  1  synchronous, active-low reset.
- flush_in  input  1  squash all queued entries; zero all outputs.
- instr_valid_in  input  1  fetch side offers instr_in / pc_in.
- instr_in  input  32  fetched instruction word.
- pc_in  input  PC_W  PC of instr_in.
- instr_ready_out  output  1  queue can accept an entry (not full).
- dec_ready_in  input  1  decoder consumes the head entry.
- dec_valid_out  output  1  head entry valid.
- opcode_out  output  7  head[6:0].
- funct3_out  output  3  head[14:12].
- funct7_out  output  7  head[31:25].
- rs1addr_out  output  5  head[19:15].
- rs2addr_out  output  5  head[24:20].
- rdaddr_out  output  5  head[11:7].
- csr_addr_out  output  12  head[31:20].
- instr_31_7_out  output  25  head[31:7].
- pc_out  output  PC_W  PC of the head entry.
- illegal_out  output  1  head[1:0] != 2'b11 (non-32-bit encoding); only meaningful when dec_valid_out=1.
- count_out  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n low at a clock edge):
  - Read pointer, write pointer and count_out go to 0.
  - dec_valid_out=0, instr_ready_out=1, all field outputs and pc_out read 0.
  - Storage arrays are not reset.
- Pointers:
  - Each pointer is $clog2(DEPTH)+1 bits, with the MSB used as the wrap bit.
  - full = (index bits equal) && (MSBs differ). empty = (pointers equal).
  - Wrap-around from entry DEPTH-1 to 0 is natural modulo arithmetic.
- Push and pop:
  - Push occurs when instr_valid_in && instr_ready_out && !flush_in.
  - instr_ready_out = !full. There is no bypass: when full, a simultaneous pop does not enable a push in the same cycle.
  - Pop occurs when dec_valid_out && dec_ready_in && !flush_in.
  - dec_valid_out = !empty && !flush_in.
  - Simultaneous push and pop while not full and not empty: count unchanged, both pointers advance.
- Latency:
  - An entry pushed at edge N is visible on the outputs after edge N (one cycle) when the queue was empty.
  - Field outputs are combinational slices of the registered head entry.
- Field zeroing:
  - When dec_valid_out=0 (empty or flush_in high), every field output, pc_out and illegal_out is driven to 0.
  - This preserves the existing flush-zero contract of the splitter.
- Flush:
  - flush_in is combinationally effective: outputs are zero in the flush cycle.
  - At the next edge both pointers go to 0 and count_out goes to 0.
  - A push offered in the flush cycle is discarded.
  - flush_in has priority over push and pop. Reset has priority over flush_in.
- Reset mid-operation: all queued entries are lost; no pop is signalled.
- Handshake stability: the queue never retracts dec_valid_out or changes the head while dec_ready_in is low, except on flush or reset.

Optional Feature:
- Macro: MSRV32_IMM_GEN_EN.
- Defined:
  - Adds output imm_out[31:0], the sign-extended immediate of the head entry, selected by opcode:
    - I-type (LOAD, OP-IMM, JALR, SYSTEM), S-type, B-type (bit 0 = 0), U-type (low 12 bits zero), J-type (bit 0 = 0).
    - Any other opcode gives 0.
  - imm_out is zeroed whenever dec_valid_out=0.
- Undefined: the port is absent and no immediate logic is generated.

Decomposition:
- Package msrv32_pkg holds:
  - opcode localparams (OPCODE_LOAD=7'b0000011, OP_IMM=7'b0010011, STORE=7'b0100011, BRANCH=7'b1100011, JAL=7'b1101111, JALR=7'b1100111, LUI=7'b0110111, AUIPC=7'b0010111, SYSTEM=7'b1110011);
  - field width constants;
  - the IMM_TYPE enum.
- One combinational sub-module, msrv32_instr_field_split:
  - inputs: 32-bit word, valid;
  - outputs: all fields plus illegal (and imm under the macro).
  - Instantiated once on the head entry.

Test Plan:
1. Reset with rst_n=0 for 2 cycles, then release → dec_valid_out=0, instr_ready_out=1, count_out=0, all fields 0.
2. Push instr 32'h01234567 at pc 32'h100 with dec_ready_in=0 → next cycle dec_valid_out=1, opcode_out=7'h67, rdaddr_out=5'h0A, funct3_out=3'h4, rs1addr_out=5'h06, rs2addr_out=5'h12, funct7_out=7'h00, csr_addr_out=12'h012, pc_out=32'h100, count_out=1.
3. Push 4 entries with dec_ready_in=0 and DEPTH=4 → count_out=4, instr_ready_out=0. A 5th push with instr_valid_in=1 is ignored; order is preserved on subsequent pops.
4. Hold simultaneous push/pop for 10 cycles at count 2 → count_out stays 2; pointers wrap; instructions pop in exact push order.
5. Full queue, assert flush_in with instr_valid_in=1 and instr 32'h89ABCDEF → outputs 0 in the same cycle; count_out=0 next cycle; 32'h89ABCDEF is never popped.
6. Push 32'h00000003 → illegal_out=0. Push 32'h00000000 → illegal_out=1. With MSRV32_IMM_GEN_EN, push 32'hFFF00093 (addi x1,x0,-1) → imm_out=32'hFFFFFFFF.

Source files
------------

// File: rtl/msrv32_pkg.sv
// msrv32_pkg: RV32 opcodes, field widths and immediate-format selection shared by the queue/decode slice.
package msrv32_pkg;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    localparam int INSTR_W    = 32;
    localparam int OPCODE_W   = 7;
    localparam int FUNCT3_W   = 3;
    localparam int FUNCT7_W   = 7;
    localparam int REG_ADDR_W = 5;
    localparam int CSR_ADDR_W = 12;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

    function automatic imm_type_e imm_type(input logic [6:0] op);
        return (op == OPCODE_LOAD || op == OPCODE_OP_IMM || op == OPCODE_JALR || op == OPCODE_SYSTEM) ? IMM_I :
               (op == OPCODE_STORE)                      ? IMM_S :
               (op == OPCODE_BRANCH)                     ? IMM_B :
               (op == OPCODE_LUI || op == OPCODE_AUIPC)  ? IMM_U :
               (op == OPCODE_JAL)                        ? IMM_J : IMM_NONE;
    endfunction
endpackage

// File: rtl/msrv32_instr_field_split.sv
// msrv32_instr_field_split: combinational RV32 field splitter; all outputs zero when the word is not valid.
// Optional immediate generator enabled by MSRV32_IMM_GEN_EN.
module msrv32_instr_field_split
    import msrv32_pkg::*;
(
    input  logic [INSTR_W-1:0]    i_word,
    input  logic                  i_valid,
    output logic [OPCODE_W-1:0]   o_opcode,
    output logic [FUNCT3_W-1:0]   o_funct3,
    output logic [FUNCT7_W-1:0]   o_funct7,
    output logic [REG_ADDR_W-1:0] o_rs1addr,
    output logic [REG_ADDR_W-1:0] o_rs2addr,
    output logic [REG_ADDR_W-1:0] o_rdaddr,
    output logic [CSR_ADDR_W-1:0] o_csr_addr,
    output logic [24:0]           o_instr_31_7,
    output logic                  o_illegal
`ifdef MSRV32_IMM_GEN_EN
    ,output logic [31:0]          o_imm
`endif
);
    logic [INSTR_W-1:0] w_word;

    assign w_word       = i_valid ? i_word : '0;
    assign o_opcode     = w_word[6:0];
    assign o_rdaddr     = w_word[11:7];
    assign o_funct3     = w_word[14:12];
    assign o_rs1addr    = w_word[19:15];
    assign o_rs2addr    = w_word[24:20];
    assign o_funct7     = w_word[31:25];
    assign o_csr_addr   = w_word[31:20];
    assign o_instr_31_7 = w_word[31:7];
    assign o_illegal    = i_valid && (w_word[1:0] != 2'b11);

`ifdef MSRV32_IMM_GEN_EN
    imm_type_e w_type;

    // A zeroed word decodes as IMM_NONE, so imm follows the valid gating for free.
    always_comb begin
        w_type = imm_type(w_word[6:0]);
        o_imm  = (w_type == IMM_I) ? {{20{w_word[31]}}, w_word[31:20]} :
                 (w_type == IMM_S) ? {{20{w_word[31]}}, w_word[31:25], w_word[11:7]} :
                 (w_type == IMM_B) ? {{19{w_word[31]}}, w_word[31], w_word[7], w_word[30:25], w_word[11:8], 1'b0} :
                 (w_type == IMM_U) ? {w_word[31:12], 12'b0} :
                 (w_type == IMM_J) ? {{11{w_word[31]}}, w_word[31], w_word[19:12], w_word[20], w_word[30:21], 1'b0} :
                 '0;
    end
`endif
endmodule

// File: rtl/msrv32_instr_queue_decode.sv
// msrv32_instr_queue_decode: DEPTH-entry instruction/PC FIFO with valid/ready on both sides, head split into RV32 fields.
// Defining MSRV32_IMM_GEN_EN adds the imm_out port.
module msrv32_instr_queue_decode
    import msrv32_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = $clog2(DEPTH) + 1
)(
    input  logic                  ms_riscv32_mp_clk_in,
    input  logic                  ms_riscv32_mp_rst_n_in,
    input  logic                  flush_in,
    input  logic                  instr_valid_in,
    input  logic [INSTR_W-1:0]    instr_in,
    input  logic [PC_W-1:0]       pc_in,
    output logic                  instr_ready_out,
    input  logic                  dec_ready_in,
    output logic                  dec_valid_out,
    output logic [OPCODE_W-1:0]   opcode_out,
    output logic [FUNCT3_W-1:0]   funct3_out,
    output logic [FUNCT7_W-1:0]   funct7_out,
    output logic [REG_ADDR_W-1:0] rs1addr_out,
    output logic [REG_ADDR_W-1:0] rs2addr_out,
    output logic [REG_ADDR_W-1:0] rdaddr_out,
    output logic [CSR_ADDR_W-1:0] csr_addr_out,
    output logic [24:0]           instr_31_7_out,
    output logic [PC_W-1:0]       pc_out,
    output logic                  illegal_out,
    output logic [CNT_W-1:0]      count_out
`ifdef MSRV32_IMM_GEN_EN
    ,output logic [31:0]          imm_out
`endif
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [INSTR_W-1:0] r_instr [DEPTH];
    logic [PC_W-1:0]    r_pc    [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr, r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_full, w_empty, w_push, w_pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign w_full          = (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]) && (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]);
    assign w_empty         = (r_wr_ptr == r_rd_ptr);
    assign instr_ready_out = !w_full;
    assign dec_valid_out   = !w_empty && !flush_in;
    assign w_push          = instr_valid_in && !w_full && !flush_in;
    assign w_pop           = dec_valid_out && dec_ready_in;
    assign count_out       = r_count;
    assign pc_out          = dec_valid_out ? r_pc[r_rd_ptr[IDX_W-1:0]] : '0;

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (w_push) begin
            r_instr[r_wr_ptr[IDX_W-1:0]] <= instr_in;
            r_pc[r_wr_ptr[IDX_W-1:0]]    <= pc_in;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_n_in || flush_in) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            r_count  <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    msrv32_instr_field_split u_split (
        .i_word       (r_instr[r_rd_ptr[IDX_W-1:0]]),
        .i_valid      (dec_valid_out),
        .o_opcode     (opcode_out),
        .o_funct3     (funct3_out),
        .o_funct7     (funct7_out),
        .o_rs1addr    (rs1addr_out),
        .o_rs2addr    (rs2addr_out),
        .o_rdaddr     (rdaddr_out),
        .o_csr_addr   (csr_addr_out),
        .o_instr_31_7 (instr_31_7_out),
        .o_illegal    (illegal_out)
`ifdef MSRV32_IMM_GEN_EN
        ,.o_imm       (imm_out)
`endif
    );
endmodule

// File: tb/tb_msrv32_instr_queue_decode.sv
// tb_msrv32_instr_queue_decode: queue-model scoreboard plus directed literal checks for the instruction queue/decoder.
module tb_msrv32_instr_queue_decode;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int CNT_W = 3;

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, ivalid = 1'b0, dready = 1'b0;
    logic [31:0] instr = '0, pc = '0;
    logic dec_valid_out, instr_ready_out, illegal_out;
    logic [6:0] opcode_out, funct7_out;
    logic [2:0] funct3_out;
    logic [4:0] rs1addr_out, rs2addr_out, rdaddr_out;
    logic [11:0] csr_addr_out;
    logic [24:0] instr_31_7_out;
    logic [31:0] pc_out;
    logic [CNT_W-1:0] count_out;
`ifdef MSRV32_IMM_GEN_EN
    logic [31:0] imm_out;
`endif

    msrv32_instr_queue_decode #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .flush_in               (flush),
        .instr_valid_in         (ivalid),
        .instr_in               (instr),
        .pc_in                  (pc),
        .instr_ready_out        (instr_ready_out),
        .dec_ready_in           (dready),
        .dec_valid_out          (dec_valid_out),
        .opcode_out             (opcode_out),
        .funct3_out             (funct3_out),
        .funct7_out             (funct7_out),
        .rs1addr_out            (rs1addr_out),
        .rs2addr_out            (rs2addr_out),
        .rdaddr_out             (rdaddr_out),
        .csr_addr_out           (csr_addr_out),
        .instr_31_7_out         (instr_31_7_out),
        .pc_out                 (pc_out),
        .illegal_out            (illegal_out),
        .count_out              (count_out)
`ifdef MSRV32_IMM_GEN_EN
        ,.imm_out               (imm_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] ins; logic [31:0] pc;} ent_t;
    ent_t q[$];
    logic [31:0] exp_pops[$];
    logic [31:0] dut_pops[$];
    int checks = 0, errors = 0;
    bit armed = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

`ifdef MSRV32_IMM_GEN_EN
    function automatic logic [31:0] imm_ref(input logic [31:0] w);
        logic [31:0] hi;
        hi = $signed(w) >>> 31;
        case (w[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: return $signed(w) >>> 20;
            7'h23: return (hi << 12) + (32'(w[31:25]) << 5) + 32'(w[11:7]);
            7'h63: return (hi << 12) + (32'(w[7]) << 11) + (32'(w[30:25]) << 5) + (32'(w[11:8]) << 1);
            7'h37, 7'h17: return w & 32'hFFFFF000;
            7'h6F: return (hi << 20) + (32'(w[19:12]) << 12) + (32'(w[20]) << 11) + (32'(w[30:21]) << 1);
            default: return 32'h0;
        endcase
    endfunction
`endif

    task automatic compare();
        bit v;
        logic [31:0] h, p;
        v = (q.size() > 0) && !flush;
        h = '0;
        p = '0;
        if (v) begin
            h = q[0].ins;
            p = q[0].pc;
        end
        chk("dec_valid", 32'(dec_valid_out), 32'(v));
        chk("instr_ready", 32'(instr_ready_out), 32'(q.size() < DEPTH));
        chk("count", 32'(count_out), q.size());
        chk("opcode", 32'(opcode_out), 32'(h[6:0]));
        chk("rd", 32'(rdaddr_out), 32'(h[11:7]));
        chk("funct3", 32'(funct3_out), 32'(h[14:12]));
        chk("rs1", 32'(rs1addr_out), 32'(h[19:15]));
        chk("rs2", 32'(rs2addr_out), 32'(h[24:20]));
        chk("funct7", 32'(funct7_out), 32'(h[31:25]));
        chk("csr", 32'(csr_addr_out), 32'(h[31:20]));
        chk("instr_31_7", 32'(instr_31_7_out), 32'(h[31:7]));
        chk("pc", pc_out, p);
        chk("illegal", 32'(illegal_out), 32'(v && h[1:0] != 2'b11));
`ifdef MSRV32_IMM_GEN_EN
        chk("imm", imm_out, v ? imm_ref(h) : 32'h0);
`endif
    endtask

    task automatic model();
        bit pop, push;
        if (!rst_n || flush) q.delete();
        else begin
            pop  = (q.size() > 0) && dready;
            push = ivalid && (q.size() < DEPTH);
            if (pop) begin
                exp_pops.push_back(q[0].ins);
                void'(q.pop_front());
            end
            if (push) q.push_back(ent_t'{instr, pc});
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (armed) begin
            compare();
            if (dec_valid_out && dready && !flush && rst_n) dut_pops.push_back({instr_31_7_out, opcode_out});
        end
        @(posedge clk);
        model();
        #1;
    endtask

    task automatic push1(input logic [31:0] ins, input logic [31:0] p);
        ivalid = 1'b1; instr = ins; pc = p;
        cyc();
        ivalid = 1'b0;
    endtask

    initial begin
        bit found;
        cyc();
        armed = 1'b1;
        cyc();
        chk("rst_dec_valid", 32'(dec_valid_out), 0);
        chk("rst_ready", 32'(instr_ready_out), 1);
        chk("rst_count", 32'(count_out), 0);
        chk("rst_opcode", 32'(opcode_out), 0);
        chk("rst_pc", pc_out, 0);
        rst_n = 1'b1;
        cyc();

        push1(32'h01234567, 32'h100);
        chk("t2_valid", 32'(dec_valid_out), 1);
        chk("t2_opcode", 32'(opcode_out), 32'h67);
        chk("t2_rd", 32'(rdaddr_out), 32'h0A);
        chk("t2_funct3", 32'(funct3_out), 32'h4);
        chk("t2_rs1", 32'(rs1addr_out), 32'h06);
        chk("t2_rs2", 32'(rs2addr_out), 32'h12);
        chk("t2_funct7", 32'(funct7_out), 32'h00);
        chk("t2_csr", 32'(csr_addr_out), 32'h012);
        chk("t2_pc", pc_out, 32'h100);
        chk("t2_count", 32'(count_out), 1);
        cyc();
        chk("t2_hold_pc", pc_out, 32'h100);
        dready = 1'b1;
        cyc();
        dready = 1'b0;
        chk("t2_drained", 32'(count_out), 0);

        ivalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            instr = 32'h00A00013 + (i << 20);
            pc = 32'h200 + 4 * i;
            cyc();
        end
        ivalid = 1'b0;
        chk("t3_count_full", 32'(count_out), 4);
        chk("t3_ready_full", 32'(instr_ready_out), 0);
        dready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_pop_pc", pc_out, 32'h200 + 4 * i);
            cyc();
        end
        chk("t3_empty_valid", 32'(dec_valid_out), 0);
        dready = 1'b0;

        push1(32'h00100093, 32'h300);
        push1(32'h00200113, 32'h304);
        ivalid = 1'b1;
        dready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            instr = 32'h00300193 + (i << 7);
            pc = 32'h308 + 4 * i;
            cyc();
            chk("t4_count_steady", 32'(count_out), 2);
        end
        ivalid = 1'b0;
        cyc();
        cyc();
        dready = 1'b0;

        for (int i = 0; i < 4; i++) push1(32'h00000033 + (i << 7), 32'h400 + 4 * i);
        ivalid = 1'b1;
        instr = 32'h89ABCDEF;
        pc = 32'h500;
        flush = 1'b1;
        #1;
        chk("t5_flush_valid", 32'(dec_valid_out), 0);
        chk("t5_flush_opcode", 32'(opcode_out), 0);
        chk("t5_flush_pc", pc_out, 0);
        chk("t5_flush_count", 32'(count_out), 4);
        cyc();
        flush = 1'b0;
        ivalid = 1'b0;
        chk("t5_count_after", 32'(count_out), 0);
        dready = 1'b1;
        cyc();
        cyc();
        chk("t5_still_empty", 32'(dec_valid_out), 0);
        dready = 1'b0;

        push1(32'h00000003, 32'h600);
        chk("t6_legal", 32'(illegal_out), 0);
        dready = 1'b1;
        cyc();
        dready = 1'b0;
        push1(32'h00000000, 32'h604);
        chk("t6_illegal", 32'(illegal_out), 1);
        dready = 1'b1;
        cyc();
        dready = 1'b0;
`ifdef MSRV32_IMM_GEN_EN
        push1(32'hFFF00093, 32'h608);
        chk("t6_imm_addi", imm_out, 32'hFFFFFFFF);
        dready = 1'b1;
        cyc();
        dready = 1'b0;
        push1(32'hFE000FA3, 32'h60C);
        push1(32'hFE000EE3, 32'h610);
        push1(32'h12345037, 32'h614);
        push1(32'hFFDFF0EF, 32'h618);
        dready = 1'b1;
        repeat (4) cyc();
        dready = 1'b0;
`endif

        push1(32'h00500293, 32'h700);
        push1(32'h00600313, 32'h704);
        rst_n = 1'b0;
        dready = 1'b1;
        cyc();
        rst_n = 1'b1;
        chk("rst_mid_count", 32'(count_out), 0);
        chk("rst_mid_valid", 32'(dec_valid_out), 0);
        cyc();
        dready = 1'b0;

        chk("pop_total", dut_pops.size(), exp_pops.size());
        for (int i = 0; i < exp_pops.size() && i < dut_pops.size(); i++) chk("pop_order", dut_pops[i], exp_pops[i]);
        found = 1'b0;
        foreach (dut_pops[i]) if (dut_pops[i] == 32'h89ABCDEF) found = 1'b1;
        chk("flushed_never_popped", 32'(found), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
